// File: rtl/bullets_pkg.sv
// Shared types for the bullet manager: slot count, coordinate type, slot state.
// Optional cooldown feature is enabled with macro BULLET_COOLDOWN_EN.
package bullets_pkg;

  localparam int NUM_BULLETS = 3;
  localparam int COORD_W     = 11;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_wide_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_e;

  // One extra bit so a box touching the right/bottom edge does not wrap to 0.
  function automatic logic in_span(input coord_t lo, input coord_t p, input int unsigned len);
    coord_wide_t lo_w;
    coord_wide_t p_w;
    coord_wide_t hi_w;
    lo_w = {1'b0, lo};
    p_w  = {1'b0, p};
    hi_w = lo_w + coord_wide_t'(len);
    return (p_w >= lo_w) && (p_w < hi_w);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: IDLE/FLYING state, position, hit/load/move update and a
// registered box hit-test against the current raster position.
module bullet_slot
  import bullets_pkg::*;
#(
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 8,
  parameter int SPEED    = 4
) (
  input  logic   clk,
  input  logic   resetN,
  input  logic   sof,
  input  logic   load,
  input  logic   hit,
  input  coord_t load_x,
  input  coord_t load_y,
  input  coord_t pixel_x,
  input  coord_t pixel_y,
  output logic   flying,
  output logic   in_box,
  output logic   draw_req
);

  slot_state_e state_q, state_d;
  coord_t      bx_q, bx_d;
  coord_t      by_q, by_d;
  logic        draw_q, draw_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      draw_q  <= draw_d;
    end
  end

  // Hit and move only touch a FLYING slot, load only an IDLE one, so a slot
  // freed by a hit cannot be reloaded in the same cycle and a fresh load is
  // never moved in its loading cycle.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    if (state_q == FLYING) begin
      if (hit) begin
        state_d = IDLE;
      end else if (sof) begin
        if (by_q >= coord_t'(SPEED)) begin
          by_d = by_q - coord_t'(SPEED);
        end else begin
          state_d = IDLE;
        end
      end
    end else if (load) begin
      state_d = FLYING;
      bx_d    = load_x;
      by_d    = load_y;
    end
  end

  always_comb begin
    in_box = (state_q == FLYING)
             && in_span(bx_q, pixel_x, BULLET_W)
             && in_span(by_q, pixel_y, BULLET_H);
    draw_d = in_box;
  end

  assign flying   = (state_q == FLYING);
  assign draw_req = draw_q;

endmodule

// File: rtl/bullets_manager.sv
// Bullet manager: allocates fire requests to the lowest free slot, drives the
// fire handshake and the bullet colour. Cooldown lockout under BULLET_COOLDOWN_EN.
module bullets_manager
  import bullets_pkg::*;
#(
  parameter int         BULLET_W        = 4,
  parameter int         BULLET_H        = 8,
  parameter int         SPEED           = 4,
  parameter logic [7:0] BULLET_COLOR    = 8'hFC,
  parameter int         COOLDOWN_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   fire,
  input  logic [10:0]            shooterX,
  input  logic [10:0]            shooterY,
  input  logic [10:0]            pixelX,
  input  logic [10:0]            pixelY,
  input  logic [NUM_BULLETS-1:0] hit,
  output logic [NUM_BULLETS-1:0] bulletDrawingRequest,
  output logic [7:0]             bulletRGB,
  output logic                   fireAck,
  output logic                   fireDropped
);

  logic [NUM_BULLETS-1:0] flying;
  logic [NUM_BULLETS-1:0] in_box;
  logic [NUM_BULLETS-1:0] load;
  logic                   any_idle;
  logic                   cool_ok;
  logic                   accept;

  logic       ack_q, ack_d;
  logic       drop_q, drop_d;
  logic [7:0] rgb_q, rgb_d;

`ifdef BULLET_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  logic [CD_W-1:0] cool_q, cool_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cool_q <= '0;
    end else begin
      cool_q <= cool_d;
    end
  end

  // An accepted fire reloads the lockout even if a frame boundary lands in the same cycle.
  always_comb begin
    cool_d = cool_q;
    if (accept) begin
      cool_d = CD_W'(COOLDOWN_FRAMES);
    end else if (startOfFrame && (cool_q != '0)) begin
      cool_d = cool_q - 1'b1;
    end
  end

  assign cool_ok = (cool_q == '0);
`else
  assign cool_ok = 1'b1;
`endif

  // Lowest-index IDLE slot wins the load.
  always_comb begin
    logic found;
    found    = 1'b0;
    load     = '0;
    any_idle = ~&flying;
    accept   = fire && any_idle && cool_ok;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!flying[i] && !found) begin
        load[i] = accept;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    ack_d  = accept;
    drop_d = fire && !accept;
    rgb_d  = (|in_box) ? BULLET_COLOR : 8'h00;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      rgb_q  <= 8'h00;
    end else begin
      ack_q  <= ack_d;
      drop_q <= drop_d;
      rgb_q  <= rgb_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
      bullet_slot #(
        .BULLET_W (BULLET_W),
        .BULLET_H (BULLET_H),
        .SPEED    (SPEED)
      ) u_slot (
        .clk      (clk),
        .resetN   (resetN),
        .sof      (startOfFrame),
        .load     (load[gi]),
        .hit      (hit[gi]),
        .load_x   (shooterX),
        .load_y   (shooterY),
        .pixel_x  (pixelX),
        .pixel_y  (pixelY),
        .flying   (flying[gi]),
        .in_box   (in_box[gi]),
        .draw_req (bulletDrawingRequest[gi])
      );
    end
  endgenerate

  assign bulletRGB   = rgb_q;
  assign fireAck     = ack_q;
  assign fireDropped = drop_q;

endmodule

// File: tb/tb_bullets_manager.sv
// Self-checking bench for bullets_manager: vector table plus scoreboard queue,
// with hand-written sequences for reset-in-flight and the cooldown option.
module tb_bullets_manager;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        fire = 1'b0;
  logic [10:0] shooterX = '0;
  logic [10:0] shooterY = '0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic [2:0]  hit = '0;
  logic [2:0]  bulletDrawingRequest;
  logic [7:0]  bulletRGB;
  logic        fireAck;
  logic        fireDropped;

  localparam logic [7:0] COLOR = 8'hFC;
  localparam int FAR = 2000;

  bullets_manager dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .fire                 (fire),
    .shooterX             (shooterX),
    .shooterY             (shooterY),
    .pixelX               (pixelX),
    .pixelY               (pixelY),
    .hit                  (hit),
    .bulletDrawingRequest (bulletDrawingRequest),
    .bulletRGB            (bulletRGB),
    .fireAck              (fireAck),
    .fireDropped          (fireDropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fire;
    logic        sof;
    logic [2:0]  hit;
    logic [10:0] sx, sy, px, py;
    logic [2:0]  req;
    logic        ack, drop;
  } vec_t;

  typedef struct {
    logic [2:0] req;
    logic [7:0] rgb;
    logic       ack, drop;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic vec_t mk(input int f, input int s, input int h, input int sx, input int sy,
                              input int px, input int py, input int req, input int ack, input int drop);
    vec_t v;
    v.fire = f[0];
    v.sof  = s[0];
    v.hit  = h[2:0];
    v.sx   = sx[10:0];
    v.sy   = sy[10:0];
    v.px   = px[10:0];
    v.py   = py[10:0];
    v.req  = req[2:0];
    v.ack  = ack[0];
    v.drop = drop[0];
    return v;
  endfunction

  function automatic vec_t fire_v(input int sx, input int sy, input int ack, input int drop);
    return mk(1, 0, 0, sx, sy, FAR, FAR, 0, ack, drop);
  endfunction

  function automatic vec_t probe_v(input int px, input int py, input int req);
    return mk(0, 0, 0, 0, 0, px, py, req, 0, 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector, predict the registered outputs, then compare after the edge.
  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    exp_t got;
    fire         = v.fire;
    startOfFrame = v.sof;
    hit          = v.hit;
    shooterX     = v.sx;
    shooterY     = v.sy;
    pixelX       = v.px;
    pixelY       = v.py;
    e.req  = v.req;
    e.rgb  = (v.req != 3'b000) ? COLOR : 8'h00;
    e.ack  = v.ack;
    e.drop = v.drop;
    e.tag  = tag;
    sb.push_back(e);
    tick();
    if (sb.size() == 0) begin
      chk("scoreboard_empty", tag, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("req",  got.tag, 32'(bulletDrawingRequest), 32'(got.req));
      chk("rgb",  got.tag, 32'(bulletRGB),            32'(got.rgb));
      chk("ack",  got.tag, 32'(fireAck),              32'(got.ack));
      chk("drop", got.tag, 32'(fireDropped),          32'(got.drop));
    end
    $display("step %0d: fire=%0b sof=%0b hit=%b px=%0d py=%0d -> req=%b rgb=%h ack=%0b drop=%0b",
             tag, v.fire, v.sof, v.hit, v.px, v.py, bulletDrawingRequest, bulletRGB, fireAck, fireDropped);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_req"},  0, 32'(bulletDrawingRequest), 32'd0);
    chk({name, "_rgb"},  0, 32'(bulletRGB),            32'd0);
    chk({name, "_ack"},  0, 32'(fireAck),              32'd0);
    chk({name, "_drop"}, 0, 32'(fireDropped),          32'd0);
  endtask

  initial begin
    // Reset: outputs cleared, an idle slot at (0,0) does not draw.
    pixelX = '0;
    pixelY = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    resetN = 1'b1;
    apply(probe_v(0, 0, 0), 900);

`ifdef BULLET_COOLDOWN_EN
    apply(fire_v(100, 400, 1, 0), 1000);
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 0, 0, FAR, FAR, 0, 0, 0), 1001 + k);
    apply(fire_v(100, 400, 0, 1), 1004);
    for (int k = 0; k < 4; k++) apply(mk(0, 1, 0, 0, 0, FAR, FAR, 0, 0, 0), 1005 + k);
    apply(fire_v(100, 400, 0, 1), 1009);
    apply(mk(0, 1, 0, 0, 0, FAR, FAR, 0, 0, 0), 1010);
    apply(fire_v(150, 450, 1, 0), 1011);
`else
    // First launch and box edges.
    vecs.push_back(fire_v(100, 400, 1, 0));
    vecs.push_back(probe_v(100, 400, 3'b001));
    vecs.push_back(probe_v(103, 407, 3'b001));
    vecs.push_back(probe_v(104, 407, 3'b000));
    vecs.push_back(probe_v(103, 408, 3'b000));
    vecs.push_back(probe_v(99, 400, 3'b000));
    // Fill remaining slots in order, then a dropped fire.
    vecs.push_back(fire_v(200, 300, 1, 0));
    vecs.push_back(probe_v(FAR, FAR, 0));
    vecs.push_back(fire_v(300, 500, 1, 0));
    vecs.push_back(probe_v(FAR, FAR, 0));
    vecs.push_back(fire_v(400, 600, 0, 1));
    vecs.push_back(probe_v(200, 300, 3'b010));
    vecs.push_back(probe_v(300, 500, 3'b100));
    vecs.push_back(probe_v(400, 600, 3'b000));
    // Hit frees slot 1 but same-cycle fire is dropped; next fire reloads it.
    vecs.push_back(mk(1, 0, 3'b010, 500, 700, FAR, FAR, 0, 0, 1));
    vecs.push_back(probe_v(200, 300, 3'b000));
    vecs.push_back(fire_v(500, 700, 1, 0));
    vecs.push_back(probe_v(500, 700, 3'b010));
    vecs.push_back(mk(0, 0, 3'b100, 0, 0, FAR, FAR, 0, 0, 0));
    vecs.push_back(probe_v(300, 500, 3'b000));
    // Hit on an idle slot is ignored; the same-cycle fire loads it.
    vecs.push_back(mk(1, 0, 3'b100, 10, 20, FAR, FAR, 0, 1, 0));
    vecs.push_back(probe_v(10, 20, 3'b100));
    // Clear all, then walk a bullet off the top without wrapping.
    vecs.push_back(mk(0, 0, 3'b111, 0, 0, FAR, FAR, 0, 0, 0));
    vecs.push_back(probe_v(100, 400, 3'b000));
    vecs.push_back(fire_v(50, 6, 1, 0));
    vecs.push_back(probe_v(50, 6, 3'b001));
    vecs.push_back(mk(0, 1, 0, 0, 0, FAR, FAR, 0, 0, 0));
    vecs.push_back(probe_v(50, 2, 3'b001));
    vecs.push_back(probe_v(53, 9, 3'b001));
    vecs.push_back(probe_v(50, 10, 3'b000));
    vecs.push_back(mk(0, 1, 0, 0, 0, FAR, FAR, 0, 0, 0));
    vecs.push_back(probe_v(50, 2, 3'b000));
    vecs.push_back(probe_v(50, 2046, 3'b000));
    // Box at the bottom-right corner must not wrap.
    vecs.push_back(fire_v(2046, 2040, 1, 0));
    vecs.push_back(probe_v(2047, 2047, 3'b001));
    vecs.push_back(probe_v(1, 2047, 3'b000));

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k], k);
    end

    // Reset mid-flight clears asynchronously and stays clear until a new fire.
    apply(probe_v(2047, 2047, 3'b001), 100);
    resetN = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    tick();
    resetN = 1'b1;
    apply(probe_v(2047, 2047, 3'b000), 101);
    apply(mk(0, 1, 0, 0, 0, 2047, 2047, 0, 0, 0), 102);
    apply(fire_v(2046, 2040, 1, 0), 103);
    apply(probe_v(2047, 2047, 3'b001), 104);
`endif

    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
